// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD scan display.
// Segment patterns are active-low: bit0=a .. bit6=g, bit7=dp (always off).
package bcd_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BCD_MAX   = 4'd9;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/bcd_scan_counter_seg7.sv
// Combinational BCD to active-low 7-segment decoder (module seg7_decode).
// Non-decimal codes 10..15 show blank.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  bcd_t       bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= BCD_MAX) begin
            seg = SEG_LUT[bcd];
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with prescaled tick and multiplexed 7-segment scan.
// Define BCD_SCAN_LZB_EN to blank leading zeros on the display (value/wrap unaffected).
module bcd_scan_counter
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [DIGITS-1:0]     sela,
    output logic [7:0]            seg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    bcd_t [DIGITS-1:0] digits_q, digits_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic              wrap_q, wrap_d;
    logic [DIGITS-1:0] sela_q, sela_d;
    logic [7:0]        seg_q, seg_d;

    logic       tick;
    logic       carry;
    logic       blank;
    bcd_t       cur_digit;
    logic [7:0] dec_seg;

    // Count path: carry/borrow ripples upward; surviving carry means full-range rollover.
    always_comb begin
        tick       = en && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        digits_d   = digits_q;
        carry      = 1'b1;
        wrap_d     = 1'b0;
        if (clr) begin
            tick_cnt_d = '0;
            digits_d   = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (up_dn) begin
                        if (digits_q[i] == BCD_MAX) begin
                            digits_d[i] = 4'd0;
                        end else begin
                            digits_d[i] = digits_q[i] + 4'd1;
                            carry       = 1'b0;
                        end
                    end else begin
                        if (digits_q[i] == 4'd0) begin
                            digits_d[i] = BCD_MAX;
                        end else begin
                            digits_d[i] = digits_q[i] - 4'd1;
                            carry       = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end else if (en) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
    end

    assign cur_digit = digits_q[scan_idx_q];

    seg7_decode u_seg7_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
`ifdef BCD_SCAN_LZB_EN
        // Blank when this position and every higher one are zero; digit 0 always shows.
        blank = (scan_idx_q != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(scan_idx_q)) && (digits_q[i] != 4'd0)) begin
                blank = 1'b0;
            end
        end
`else
        blank = 1'b0;
`endif
        sela_d             = '1;
        sela_d[scan_idx_q] = 1'b0;
        seg_d              = blank ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            digits_q   <= '0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            wrap_q     <= 1'b0;
            sela_q     <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            digits_q   <= digits_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            wrap_q     <= wrap_d;
            sela_q     <= sela_d;
            seg_q      <= seg_d;
        end
    end

    assign value = digits_q;
    assign wrap  = wrap_q;
    assign sela  = sela_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench: instance A (TICK_DIV=1, SCAN_DIV=1), instance B (TICK_DIV=5, SCAN_DIV=2).
module tb_bcd_scan_counter;

    logic clock = 1'b0;
    logic reset;
    logic en_a, up_a, clr_a;
    logic en_b, up_b, clr_b;
    logic [15:0] value_a, value_b;
    logic        wrap_a, wrap_b;
    logic [3:0]  sela_a, sela_b;
    logic [7:0]  seg_a, seg_b;

    always #5 clock = ~clock;

    bcd_scan_counter #(.DIGITS(4), .TICK_DIV(1), .SCAN_DIV(1)) u_dut_a (
        .clock(clock), .reset(reset), .en(en_a), .up_dn(up_a), .clr(clr_a),
        .value(value_a), .wrap(wrap_a), .sela(sela_a), .seg(seg_a)
    );

    bcd_scan_counter #(.DIGITS(4), .TICK_DIV(5), .SCAN_DIV(2)) u_dut_b (
        .clock(clock), .reset(reset), .en(en_b), .up_dn(up_b), .clr(clr_b),
        .value(value_b), .wrap(wrap_b), .sela(sela_b), .seg(seg_b)
    );

    typedef struct packed {
        logic [15:0] val;
        logic        wrap;
    } exp_t;

    localparam logic [7:0] LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   model_a = 0;
    int   model_b = 0;
    int   tcnt_b  = 0;

    function automatic logic [15:0] to_bcd(input int v);
        int x = v;
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int x = v;
        for (int i = 0; i < idx; i++) x = x / 10;
        return x % 10;
    endfunction

    function automatic int idx_of(input logic [3:0] s);
        int r = 0;
        for (int i = 0; i < 4; i++) if (s[i] == 1'b0) r = i;
        return r;
    endfunction

    function automatic exp_t step_model_a(input logic en, input logic up, input logic clr);
        exp_t e;
        e.wrap = 1'b0;
        if (clr) begin
            model_a = 0;
        end else if (en) begin
            if (up) begin
                e.wrap  = (model_a == 9999);
                model_a = (model_a + 1) % 10000;
            end else begin
                e.wrap  = (model_a == 0);
                model_a = (model_a + 9999) % 10000;
            end
        end
        e.val = to_bcd(model_a);
        return e;
    endfunction

    function automatic exp_t step_model_b(input logic en, input logic up, input logic clr);
        exp_t e;
        e.wrap = 1'b0;
        if (clr) begin
            model_b = 0;
            tcnt_b  = 0;
        end else if (en) begin
            if (tcnt_b == 4) begin
                tcnt_b = 0;
                if (up) begin
                    e.wrap  = (model_b == 9999);
                    model_b = (model_b + 1) % 10000;
                end else begin
                    e.wrap  = (model_b == 0);
                    model_b = (model_b + 9999) % 10000;
                end
            end else begin
                tcnt_b = tcnt_b + 1;
            end
        end
        e.val = to_bcd(model_b);
        return e;
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en_a = 0; up_a = 0; clr_a = 0;
        en_b = 0; up_b = 0; clr_b = 0;
        repeat (3) cycle();
        checks++; if (value_a !== 16'h0000) begin errors++; $display("FAIL reset_value_a got %h want 0000", value_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_a got %b want 0", wrap_a); end
        checks++; if (sela_a !== 4'b1111) begin errors++; $display("FAIL reset_sela_a got %b want 1111", sela_a); end
        checks++; if (seg_a !== 8'hFF) begin errors++; $display("FAIL reset_seg_a got %h want ff", seg_a); end
        checks++; if (value_b !== 16'h0000) begin errors++; $display("FAIL reset_value_b got %h want 0000", value_b); end
        checks++; if (sela_b !== 4'b1111) begin errors++; $display("FAIL reset_sela_b got %b want 1111", sela_b); end
        checks++; if (seg_b !== 8'hFF) begin errors++; $display("FAIL reset_seg_b got %h want ff", seg_b); end
        reset = 1'b1;
        model_a = 0; model_b = 0; tcnt_b = 0;
    endtask

    task automatic test_up_rollover();
        exp_t e;
        int   wraps = 0;
        clr_a = 1; en_a = 0; up_a = 1;
        exp_q.push_back(step_model_a(0, 1, 1));
        cycle();
        e = exp_q.pop_front();
        checks++; if (value_a !== e.val) begin errors++; $display("FAIL up_clr got %h want %h", value_a, e.val); end
        clr_a = 0; en_a = 1;
        for (int n = 0; n < 10000; n++) begin
            exp_q.push_back(step_model_a(1, 1, 0));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_a !== e.val) begin errors++; $display("FAIL up_value n=%0d got %h want %h", n, value_a, e.val); end
            checks++; if (wrap_a !== e.wrap) begin errors++; $display("FAIL up_wrap n=%0d got %b want %b", n, wrap_a, e.wrap); end
            if (wrap_a === 1'b1) wraps++;
        end
        checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_count got %0d want 1", wraps); end
        en_a = 0;
        exp_q.push_back(step_model_a(0, 1, 0));
        cycle();
        e = exp_q.pop_front();
        checks++; if (value_a !== e.val) begin errors++; $display("FAIL up_hold got %h want %h", value_a, e.val); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL up_wrap_pulse got %b want 0", wrap_a); end
    endtask

    task automatic test_down_borrow();
        logic [2:0] stim[$];
        exp_t e;
        stim = '{3'b001, 3'b100, 3'b100, 3'b000};
        foreach (stim[k]) begin
            {en_a, up_a, clr_a} = stim[k];
            exp_q.push_back(step_model_a(stim[k][2], stim[k][1], stim[k][0]));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_a !== e.val) begin errors++; $display("FAIL down_value k=%0d got %h want %h", k, value_a, e.val); end
            checks++; if (wrap_a !== e.wrap) begin errors++; $display("FAIL down_wrap k=%0d got %b want %b", k, wrap_a, e.wrap); end
        end
    endtask

    task automatic test_clr_tick();
        logic [2:0] stim[$];
        exp_t e;
        stim.push_back(3'b001);
        repeat (123) stim.push_back(3'b110);
        stim.push_back(3'b111);
        stim.push_back(3'b100);
        stim.push_back(3'b111);
        stim.push_back(3'b101);
        stim.push_back(3'b000);
        foreach (stim[k]) begin
            {en_a, up_a, clr_a} = stim[k];
            exp_q.push_back(step_model_a(stim[k][2], stim[k][1], stim[k][0]));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_a !== e.val) begin errors++; $display("FAIL clr_value k=%0d got %h want %h", k, value_a, e.val); end
            checks++; if (wrap_a !== e.wrap) begin errors++; $display("FAIL clr_wrap k=%0d got %b want %b", k, wrap_a, e.wrap); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic ren, rup, rclr;
        for (int n = 0; n < 400; n++) begin
            ren  = ($urandom_range(0, 3) != 0);
            rup  = ($urandom_range(0, 4) < 2);
            rclr = ($urandom_range(0, 31) == 0);
            en_a = ren; up_a = rup; clr_a = rclr;
            exp_q.push_back(step_model_a(ren, rup, rclr));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_a !== e.val) begin errors++; $display("FAIL b2b_value n=%0d got %h want %h", n, value_a, e.val); end
            checks++; if (wrap_a !== e.wrap) begin errors++; $display("FAIL b2b_wrap n=%0d got %b want %b", n, wrap_a, e.wrap); end
        end
        en_a = 0; clr_a = 0;
    endtask

    task automatic test_prescale();
        exp_t e;
        logic ren;
        up_b = 1; clr_b = 0;
        for (int n = 0; n < 8000; n++) begin
            ren  = !(n >= 12 && n < 19);
            en_b = ren;
            exp_q.push_back(step_model_b(ren, 1'b1, 1'b0));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_b !== e.val) begin errors++; $display("FAIL presc_value n=%0d got %h want %h", n, value_b, e.val); end
            checks++; if (wrap_b !== e.wrap) begin errors++; $display("FAIL presc_wrap n=%0d got %b want %b", n, wrap_b, e.wrap); end
            if (n >= 19 && model_b == 1234) break;
        end
        en_b = 0;
        checks++; if (value_b !== 16'h1234) begin errors++; $display("FAIL presc_reach got %h want 1234", value_b); end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] exp_sela;
        logic [7:0] exp_seg;
        int start, idx;
        bit changed = 0;
        cycle();
        prev = sela_b;
        for (int n = 0; n < 4 && !changed; n++) begin
            cycle();
            if (sela_b !== prev) changed = 1;
        end
        checks++; if (!changed) begin errors++; $display("FAIL scan_step_seen got none want change"); end
        start = idx_of(sela_b);
        for (int k = 0; k < 16; k++) begin
            idx      = (start + k / 2) % 4;
            exp_sela = ~(4'b0001 << idx);
            exp_seg  = LUT[digit_of(1234, idx)];
            checks++; if (sela_b !== exp_sela) begin errors++; $display("FAIL scan_sela k=%0d got %b want %b", k, sela_b, exp_sela); end
            checks++; if (seg_b !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg_b, exp_seg); end
            cycle();
        end
    endtask

    task automatic test_lzb();
        exp_t e;
        logic [7:0] exp_seg;
        logic [3:0] seen;
        int idx, d, val;
        for (int pass = 0; pass < 2; pass++) begin
            clr_a = 1; en_a = 0; up_a = 1;
            exp_q.push_back(step_model_a(0, 1, 1));
            cycle();
            e = exp_q.pop_front();
            checks++; if (value_a !== e.val) begin errors++; $display("FAIL lzb_clr got %h want %h", value_a, e.val); end
            clr_a = 0;
            val = (pass == 0) ? 12 : 0;
            for (int t = 0; t < val; t++) begin
                en_a = 1;
                exp_q.push_back(step_model_a(1, 1, 0));
                cycle();
                e = exp_q.pop_front();
                checks++; if (value_a !== e.val) begin errors++; $display("FAIL lzb_count got %h want %h", value_a, e.val); end
            end
            en_a = 0;
            cycle();
            seen = '0;
            for (int k = 0; k < 8; k++) begin
                checks++; if ($countones(~sela_a) != 1) begin errors++; $display("FAIL lzb_sela_onehot got %b want one zero", sela_a); end
                idx = idx_of(sela_a);
                seen[idx] = 1'b1;
                d = digit_of(val, idx);
                exp_seg = LUT[d];
`ifdef BCD_SCAN_LZB_EN
                if (idx > 0 && (val / (idx == 1 ? 10 : (idx == 2 ? 100 : 1000))) == 0) exp_seg = 8'hFF;
`endif
                checks++; if (seg_a !== exp_seg) begin errors++; $display("FAIL lzb_seg val=%0d idx=%0d got %h want %h", val, idx, seg_a, exp_seg); end
                cycle();
            end
            checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL lzb_positions got %b want 1111", seen); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_up_rollover();
        test_down_borrow();
        test_clr_tick();
        test_back_to_back();
        test_prescale();
        test_scan();
        test_lzb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
